hazard_control: RTL and testbench

Pipeline hazard controller for the five-stage RV32 core; sits beside the execution stage. It produces the operand-forwarding selects for the EX operand muxes. It also detects load-use hazards and sequences stalls and bubbles, including multi-cycle mul/div occupancy of EX. Branch/jump flushes resolved in MEM are handled here too, so EX, fetch and decode see one consistent stall/flush view.

---
 rtl/core_pkg.sv | 20 ++
 rtl/hazard_control_fwd_unit.sv | 24 ++
 rtl/hazard_control.sv | 143 ++++++++++++++
 tb/tb_hazard_control.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32 pipeline control blocks: register-index
// width, forwarding-select encodings and the hazard controller FSM states.
package core_pkg;

  localparam int              REG_W    = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_DECODE = 2'b00,
    FWD_MEM    = 2'b01,
    FWD_WB     = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MD_BUSY = 2'b01,
    ST_FLUSH   = 2'b10
  } hc_state_e;

endpackage

// File: rtl/hazard_control_fwd_unit.sv
// Operand-forwarding compare for one EX operand: picks the youngest in-flight
// producer of the source register, or the decoded operand when none matches.
module fwd_unit
  import core_pkg::*;
(
  input  logic [REG_W-1:0] i_rs_exec,
  input  logic [REG_W-1:0] i_rd_mem,
  input  logic             i_wr_en_mem,
  input  logic [REG_W-1:0] i_rd_wb,
  input  logic             i_wr_en_wb,
  output logic [1:0]       o_sel
);

  // NOTE: give every always_comb output a default first so no path can leave it unassigned (a latch).
  always_comb begin
    o_sel = FWD_DECODE;
    if (i_wr_en_mem && (i_rd_mem != REG_ZERO) && (i_rd_mem == i_rs_exec)) begin
      o_sel = FWD_MEM;
    end else if (i_wr_en_wb && (i_rd_wb != REG_ZERO) && (i_rd_wb == i_rs_exec)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller beside EX: operand forwarding, load-use stalls,
// multi-cycle mul/div occupancy and MEM-resolved branch flushes.
module hazard_control
  import core_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] Rsrc1_Decode,
  input  logic [REG_W-1:0] Rsrc2_Decode,
  input  logic             use_rs1_Decode,
  input  logic             use_rs2_Decode,
  input  logic [REG_W-1:0] Rsrc1_Exec,
  input  logic [REG_W-1:0] Rsrc2_Exec,
  input  logic [REG_W-1:0] Rd_Exec,
  input  logic             memRead_Exec,
  input  logic             valid_Exec,
  input  logic [REG_W-1:0] Rd_Mem,
  input  logic             regWrEn_Mem,
  input  logic [REG_W-1:0] Rd_WB,
  input  logic             wrEn_WB,
  input  logic             md_start_Exec,
  input  logic             jump_flag_Mem,
  output logic [1:0]       fwd_A_sel,
  output logic [1:0]       fwd_B_sel,
  output logic             stall_Fetch,
  output logic             stall_Decode,
  output logic             stall_Exec,
  output logic             bubble_Exec,
  output logic             flush_Decode,
  output logic             flush_Exec,
  output logic             md_busy,
  output logic             md_done
);

  // The start cycle is itself the first stall cycle, so the counter enters
  // MD_BUSY already one step down from MD_LATENCY-1.
  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 2);

  hc_state_e  r_state;
  hc_state_e  w_state_nxt;
  logic [3:0] r_md_cnt;
  logic [3:0] w_md_cnt_nxt;
  logic       w_md_active;
  logic       w_md_stall;
  logic       w_md_done;
  logic       w_load_use;
  logic       w_lu_stall;
  logic       w_live;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  fwd_unit u_fwd_a (
    .i_rs_exec  (Rsrc1_Exec),
    .i_rd_mem   (Rd_Mem),
    .i_wr_en_mem(regWrEn_Mem),
    .i_rd_wb    (Rd_WB),
    .i_wr_en_wb (wrEn_WB),
    .o_sel      (w_fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_rs_exec  (Rsrc2_Exec),
    .i_rd_mem   (Rd_Mem),
    .i_wr_en_mem(regWrEn_Mem),
    .i_rd_wb    (Rd_WB),
    .i_wr_en_wb (wrEn_WB),
    .o_sel      (w_fwd_b)
  );

  assign w_load_use = valid_Exec && memRead_Exec && (Rd_Exec != REG_ZERO) &&
                      ((use_rs1_Decode && (Rd_Exec == Rsrc1_Decode)) ||
                       (use_rs2_Decode && (Rd_Exec == Rsrc2_Decode)));

  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_md_active  = 1'b0;
    w_md_stall   = 1'b0;
    w_md_done    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (md_start_Exec && valid_Exec) begin
          w_state_nxt  = ST_MD_BUSY;
          w_md_cnt_nxt = MD_LOAD;
          w_md_active  = 1'b1;
          w_md_stall   = 1'b1;
        end
      end
      ST_MD_BUSY: begin
        w_md_active = 1'b1;
        if (r_md_cnt != 4'd0) begin
          w_md_stall   = 1'b1;
          w_md_cnt_nxt = r_md_cnt - 4'd1;
        end else begin
          w_md_done   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        w_state_nxt  = ST_IDLE;
        w_md_cnt_nxt = 4'd0;
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_md_cnt_nxt = 4'd0;
      end
    endcase
    // A taken branch discards the younger mul/div wherever the FSM is.
    if (jump_flag_Mem) begin
      w_state_nxt  = ST_FLUSH;
      w_md_cnt_nxt = 4'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_md_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Reset is synchronous, but outputs must read as idle while it is held.
  assign w_live     = !reset && !jump_flag_Mem;
  assign w_lu_stall = w_load_use && !w_md_active;

  assign fwd_A_sel    = reset ? FWD_DECODE : w_fwd_a;
  assign fwd_B_sel    = reset ? FWD_DECODE : w_fwd_b;
  assign flush_Decode = !reset && jump_flag_Mem;
  assign flush_Exec   = !reset && jump_flag_Mem;
  assign stall_Fetch  = w_live && (w_md_stall || w_lu_stall);
  assign stall_Decode = w_live && (w_md_stall || w_lu_stall);
  assign stall_Exec   = w_live && w_md_stall;
  assign bubble_Exec  = w_live && w_lu_stall;
  assign md_busy      = w_live && w_md_active;
  assign md_done      = w_live && w_md_done;

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: directed scenarios plus a random
// run, all compared against a cycle-count reference model of the controller.
module tb_hazard_control;

  localparam int L = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] Rsrc1_Decode, Rsrc2_Decode, Rsrc1_Exec, Rsrc2_Exec;
  logic [4:0] Rd_Exec, Rd_Mem, Rd_WB;
  logic       use_rs1_Decode, use_rs2_Decode, memRead_Exec, valid_Exec;
  logic       regWrEn_Mem, wrEn_WB, md_start_Exec, jump_flag_Mem;
  logic [1:0] fwd_A_sel, fwd_B_sel;
  logic       stall_Fetch, stall_Decode, stall_Exec, bubble_Exec;
  logic       flush_Decode, flush_Exec, md_busy, md_done;

  int tests = 0;
  int fails = 0;
  int md_left;   // cycles of mul/div still to run, counting the current one
  bit in_flush;  // previous cycle resolved a taken branch

  always #5 clock = ~clock;

  hazard_control #(.MD_LATENCY(L)) dut (
    .clock(clock), .reset(reset),
    .Rsrc1_Decode(Rsrc1_Decode), .Rsrc2_Decode(Rsrc2_Decode),
    .use_rs1_Decode(use_rs1_Decode), .use_rs2_Decode(use_rs2_Decode),
    .Rsrc1_Exec(Rsrc1_Exec), .Rsrc2_Exec(Rsrc2_Exec),
    .Rd_Exec(Rd_Exec), .memRead_Exec(memRead_Exec), .valid_Exec(valid_Exec),
    .Rd_Mem(Rd_Mem), .regWrEn_Mem(regWrEn_Mem), .Rd_WB(Rd_WB), .wrEn_WB(wrEn_WB),
    .md_start_Exec(md_start_Exec), .jump_flag_Mem(jump_flag_Mem),
    .fwd_A_sel(fwd_A_sel), .fwd_B_sel(fwd_B_sel),
    .stall_Fetch(stall_Fetch), .stall_Decode(stall_Decode), .stall_Exec(stall_Exec),
    .bubble_Exec(bubble_Exec), .flush_Decode(flush_Decode), .flush_Exec(flush_Exec),
    .md_busy(md_busy), .md_done(md_done)
  );

  // Bit order: fwdA[11:10] fwdB[9:8] sF sD sE bub flD flE busy done
  function automatic logic [11:0] obs();
    return {fwd_A_sel, fwd_B_sel, stall_Fetch, stall_Decode, stall_Exec, bubble_Exec,
            flush_Decode, flush_Exec, md_busy, md_done};
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (regWrEn_Mem && Rd_Mem != 5'd0 && Rd_Mem == rs) return 2'b01;
    if (wrEn_WB && Rd_WB != 5'd0 && Rd_WB == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int eff_left();
    if (md_left == 0 && !in_flush && md_start_Exec && valid_Exec) return L;
    return md_left;
  endfunction

  function automatic logic [11:0] model();
    int  eff;
    bit  lu;
    logic [1:0] fa, fb;
    if (reset) return 12'd0;
    fa = ref_fwd(Rsrc1_Exec);
    fb = ref_fwd(Rsrc2_Exec);
    if (jump_flag_Mem) return {fa, fb, 4'b0000, 2'b11, 2'b00};
    eff = eff_left();
    lu = valid_Exec && memRead_Exec && Rd_Exec != 5'd0 && eff == 0 &&
         ((use_rs1_Decode && Rd_Exec == Rsrc1_Decode) ||
          (use_rs2_Decode && Rd_Exec == Rsrc2_Decode));
    return {fa, fb, (eff > 1) || lu, (eff > 1) || lu, eff > 1, lu, 2'b00, eff > 0, eff == 1};
  endfunction

  // Advance one clock; model state follows the inputs seen at the edge.
  task automatic tick();
    int eff;
    @(posedge clock);
    eff = eff_left();
    if (reset) begin
      md_left = 0; in_flush = 0;
    end else if (jump_flag_Mem) begin
      md_left = 0; in_flush = 1;
    end else begin
      md_left = (eff > 0) ? eff - 1 : 0; in_flush = 0;
    end
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    {Rsrc1_Decode, Rsrc2_Decode, Rsrc1_Exec, Rsrc2_Exec, Rd_Exec, Rd_Mem, Rd_WB} = '0;
    {use_rs1_Decode, use_rs2_Decode, memRead_Exec, valid_Exec} = '0;
    {regWrEn_Mem, wrEn_WB, md_start_Exec, jump_flag_Mem} = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    md_start_Exec = 1; valid_Exec = 1; jump_flag_Mem = 1;
    Rd_Mem = 5'd3; regWrEn_Mem = 1; Rsrc1_Exec = 5'd3;
    for (int k = 0; k < 2; k++) begin
      #1; tests++;
      if (obs() !== 12'd0) begin
        fails++; $display("FAIL reset_hold k=%0d got=%b want=%b", k, obs(), 12'd0);
      end
      tick();
    end
    reset = 1'b0;
    clear_inputs();
    #1; tests++;
    if (obs() !== 12'd0) begin
      fails++; $display("FAIL reset_release got=%b want=%b", obs(), 12'd0);
    end
    tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    Rd_Mem = 5'd5; regWrEn_Mem = 1; Rd_WB = 5'd5; wrEn_WB = 1; Rsrc1_Exec = 5'd5;
    #1; tests++;
    if (fwd_A_sel !== 2'b01) begin
      fails++; $display("FAIL fwd_mem_wins got=%b want=01", fwd_A_sel);
    end
    tick();
    regWrEn_Mem = 0;
    #1; tests++;
    if (fwd_A_sel !== 2'b10) begin
      fails++; $display("FAIL fwd_wb got=%b want=10", fwd_A_sel);
    end
    tick();
    regWrEn_Mem = 1; Rd_Mem = 5'd0; Rd_WB = 5'd0; Rsrc1_Exec = 5'd0;
    #1; tests++;
    if (fwd_A_sel !== 2'b00) begin
      fails++; $display("FAIL fwd_x0 got=%b want=00", fwd_A_sel);
    end
    tick();
    Rd_WB = 5'd9; Rsrc2_Exec = 5'd9; Rsrc1_Exec = 5'd8; Rd_Mem = 5'd8;
    #1; tests++;
    if ({fwd_A_sel, fwd_B_sel} !== 4'b0110) begin
      fails++; $display("FAIL fwd_both got=%b want=0110", {fwd_A_sel, fwd_B_sel});
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    Rd_Exec = 5'd7; memRead_Exec = 1; valid_Exec = 1;
    Rsrc1_Decode = 5'd3; use_rs1_Decode = 1; Rsrc2_Decode = 5'd7; use_rs2_Decode = 1;
    #1; tests++;
    if ({stall_Fetch, stall_Decode, stall_Exec, bubble_Exec} !== 4'b1101) begin
      fails++; $display("FAIL load_use got=%b want=1101",
                        {stall_Fetch, stall_Decode, stall_Exec, bubble_Exec});
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      memRead_Exec = (k != 0); use_rs2_Decode = (k != 1);
      Rd_Exec = (k == 2) ? 5'd0 : 5'd7; Rsrc1_Decode = (k == 2) ? 5'd0 : 5'd3;
      valid_Exec = (k != 3);
      if (k == 0) use_rs2_Decode = 1;
      if (k >= 2) use_rs2_Decode = 1;
      if (k == 1) begin memRead_Exec = 1; end
      #1; tests++;
      if ({stall_Fetch, stall_Decode, bubble_Exec} !== 3'b000) begin
        fails++; $display("FAIL load_use_none k=%0d got=%b want=000",
                          k, {stall_Fetch, stall_Decode, bubble_Exec});
      end
      tick();
    end
  endtask

  task automatic test_muldiv();
    clear_inputs();
    md_start_Exec = 1; valid_Exec = 1;
    for (int k = 0; k < L + 1; k++) begin
      if (k == L) md_start_Exec = 0;
      #1; tests++;
      if (stall_Exec !== (k < L - 1) || md_done !== (k == L - 1) || md_busy !== (k < L)) begin
        fails++; $display("FAIL muldiv k=%0d got sE=%b done=%b busy=%b", k, stall_Exec, md_done, md_busy);
      end
      tests++;
      if (obs() !== model()) begin
        fails++; $display("FAIL muldiv_model k=%0d got=%b want=%b", k, obs(), model());
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    valid_Exec = 1;
    for (int k = 0; k < 2 * L + 1; k++) begin
      md_start_Exec = (k < 2 * L);
      #1; tests++;
      if (stall_Exec !== ((k % L) < L - 1 && k < 2 * L) || md_done !== ((k % L) == L - 1)) begin
        fails++; $display("FAIL back_to_back k=%0d got sE=%b done=%b", k, stall_Exec, md_done);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    clear_inputs();
    md_start_Exec = 1; valid_Exec = 1;
    #1; tick();
    jump_flag_Mem = 1;
    #1; tests++;
    if ({flush_Decode, flush_Exec, stall_Fetch, stall_Decode, stall_Exec, md_done, md_busy} !== 7'b1100000) begin
      fails++; $display("FAIL flush_md got=%b want=1100000",
                        {flush_Decode, flush_Exec, stall_Fetch, stall_Decode, stall_Exec, md_done, md_busy});
    end
    tick();
    jump_flag_Mem = 0;
    #1; tests++;
    if ({stall_Exec, md_busy, md_done, flush_Exec} !== 4'b0000) begin
      fails++; $display("FAIL flush_recover got=%b want=0000", {stall_Exec, md_busy, md_done, flush_Exec});
    end
    tick();
    #1; tests++;
    if (stall_Exec !== 1'b1 || md_busy !== 1'b1) begin
      fails++; $display("FAIL flush_idle_restart got sE=%b busy=%b want 1 1", stall_Exec, md_busy);
    end
    tick();
    do_reset();
  endtask

  task automatic test_lu_during_md();
    int bubbles = 0;
    clear_inputs();
    md_start_Exec = 1; valid_Exec = 1; Rd_Exec = 5'd7; memRead_Exec = 1;
    Rsrc2_Decode = 5'd7; use_rs2_Decode = 1;
    for (int k = 0; k < L + 2; k++) begin
      if (k == L) md_start_Exec = 0;
      if (k == L + 1) memRead_Exec = 0;
      #1;
      if (bubble_Exec) bubbles++;
      tests++;
      if (bubble_Exec !== (k == L)) begin
        fails++; $display("FAIL lu_during_md k=%0d got=%b want=%b", k, bubble_Exec, (k == L));
      end
      tick();
    end
    tests++;
    if (bubbles != 1) begin
      fails++; $display("FAIL lu_after_md_count got=%0d want=1", bubbles);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    md_start_Exec = 1; valid_Exec = 1;
    #1; tick(); #1; tick();
    reset = 1; md_start_Exec = 0;
    #1; tests++;
    if (obs() !== 12'd0) begin
      fails++; $display("FAIL reset_mid_hold got=%b want=%b", obs(), 12'd0);
    end
    tick();
    reset = 0;
    for (int k = 0; k < L; k++) begin
      #1; tests++;
      if (obs() !== 12'd0) begin
        fails++; $display("FAIL reset_mid_after k=%0d got=%b want=%b", k, obs(), 12'd0);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      reset          = ($urandom_range(0, 63) == 0);
      Rsrc1_Decode   = 5'($urandom_range(0, 3));
      Rsrc2_Decode   = 5'($urandom_range(0, 3));
      Rsrc1_Exec     = 5'($urandom_range(0, 3));
      Rsrc2_Exec     = 5'($urandom_range(0, 3));
      Rd_Exec        = 5'($urandom_range(0, 3));
      Rd_Mem         = 5'($urandom_range(0, 3));
      Rd_WB          = 5'($urandom_range(0, 3));
      use_rs1_Decode = 1'($urandom_range(0, 1));
      use_rs2_Decode = 1'($urandom_range(0, 1));
      memRead_Exec   = 1'($urandom_range(0, 1));
      valid_Exec     = ($urandom_range(0, 3) != 0);
      regWrEn_Mem    = 1'($urandom_range(0, 1));
      wrEn_WB        = 1'($urandom_range(0, 1));
      md_start_Exec  = ($urandom_range(0, 5) == 0);
      jump_flag_Mem  = ($urandom_range(0, 15) == 0);
      #1; tests++;
      if (obs() !== model()) begin
        fails++; $display("FAIL random n=%0d got=%b want=%b", n, obs(), model());
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    md_left = 0; in_flush = 0;
    reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    test_reset();
    test_forwarding();
    test_load_use();
    test_muldiv();
    test_back_to_back();
    test_flush();
    test_lu_during_md();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
